// File: rtl/apb_reg_mem_bank_pkg.sv
// Shared types for the APB register/memory bank: FSM states, decode regions
// and the read-latency ceiling that sizes the wait counter.
package apbDecode_package;

  localparam int MEM_RD_LAT_MAX = 7;
  localparam int CNT_W          = $clog2(MEM_RD_LAT_MAX + 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_e;
  typedef enum logic [1:0] {RW, RO, MEM, ERR} region_e;

endpackage

// File: rtl/apb_region_decode.sv
// Combinational APB address decode into region and word index.
// Register space wins over the memory window if the two ever overlap.
module apb_region_decode
  import apbDecode_package::*;
#(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 4,
  parameter int MEM_BASE  = 'h100,
  parameter int MEM_DEPTH = 64,
  parameter int IDX_W     = 6
) (
  input  logic [ADDR_W-1:0] paddr_i,
  output region_e           region_o,
  output logic [IDX_W-1:0]  index_o
);

  localparam int WORD_W = ADDR_W - 2;
  localparam logic [ADDR_W-1:0] MEM_LO = ADDR_W'(MEM_BASE);
  localparam logic [ADDR_W:0]   MEM_HI = (ADDR_W+1)'(MEM_BASE + MEM_DEPTH * (DATA_W / 8));

  logic [WORD_W-1:0] word;
  logic [ADDR_W-1:0] mem_off;

  assign word    = paddr_i[ADDR_W-1:2];
  assign mem_off = paddr_i - MEM_LO;

  always_comb begin
    region_o = ERR;
    index_o  = '0;
    if (word < WORD_W'(NUM_REGS)) begin
      region_o = RW;
      index_o  = IDX_W'(word);
    end else if (word < WORD_W'(2 * NUM_REGS)) begin
      region_o = RO;
      index_o  = IDX_W'(word - WORD_W'(NUM_REGS));
    end else if (paddr_i >= MEM_LO && {1'b0, paddr_i} < MEM_HI) begin
      region_o = MEM;
      index_o  = IDX_W'(mem_off >> 2);
    end
  end

endmodule

// File: rtl/apb_reg_mem_bank.sv
// APB slave with RW control regs, RO status words and a word-addressed memory
// window with programmable read latency. Byte strobes honoured with APB_PSTRB_EN.
module apb_reg_mem_bank
  import apbDecode_package::*;
#(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 32,
  parameter int NUM_REGS   = 4,
  parameter int MEM_BASE   = 'h100,
  parameter int MEM_DEPTH  = 64,
  parameter int MEM_RD_LAT = 1,
  parameter logic [DATA_W-1:0] REG_RST = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [ADDR_W-1:0]            paddr,
  input  logic [DATA_W-1:0]            pwdata,
  input  logic [DATA_W/8-1:0]          pstrb,
  output logic [DATA_W-1:0]            prdata,
  output logic                         pready,
  output logic                         pslverr,
  output logic [NUM_REGS*DATA_W-1:0]   rw_q,
  output logic [NUM_REGS-1:0]          rw_wr_stb,
  input  logic [NUM_REGS*DATA_W-1:0]   ro_d,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
  output logic                         mem_rd,
  output logic                         mem_wr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int MEM_AW = $clog2(MEM_DEPTH);
  localparam int REG_AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int IDX_W  = (MEM_AW > REG_AW) ? MEM_AW : REG_AW;

  state_e                            state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  region_e                           region_q, dec_region;
  logic [IDX_W-1:0]                  idx_q, dec_idx;
  logic                              write_q, err_q, err_d;
  logic [DATA_W-1:0]                 rdata_q, mem_wdata_q;
  logic                              mem_wr_q;
  logic [NUM_REGS-1:0]               rw_wr_stb_q;
  logic [NUM_REGS-1:0][DATA_W-1:0]   regs_q;
  logic                              setup_idle, acc_idle, cap;
  logic                              rw_commit, mem_commit;
  logic [STRB_W-1:0]                 strb_eff;
  logic                              strb_err;

  apb_region_decode #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .MEM_BASE (MEM_BASE),
    .MEM_DEPTH(MEM_DEPTH),
    .IDX_W    (IDX_W)
  ) u_dec (
    .paddr_i (paddr),
    .region_o(dec_region),
    .index_o (dec_idx)
  );

`ifdef APB_PSTRB_EN
  assign strb_eff = pstrb;
  assign strb_err = (region_q == MEM) && write_q && !(&pstrb);
`else
  logic unused_pstrb;
  assign unused_pstrb = ^pstrb;
  assign strb_eff     = '1;
  assign strb_err     = 1'b0;
`endif

  assign setup_idle = (state_q == IDLE) && psel && !penable;
  assign acc_idle   = (state_q == IDLE) && psel && penable;
  assign err_d      = (region_q == ERR) || (region_q == RO && write_q) || strb_err;
  assign rw_commit  = acc_idle && region_q == RW && write_q;
  assign mem_commit = acc_idle && region_q == MEM && write_q && !strb_err;

  // Read strobe fires in the access cycle so data lands MEM_RD_LAT cycles later.
  assign mem_rd = !rst && acc_idle && region_q == MEM && !write_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && penable) begin
          if (region_q == MEM && !write_q) begin
            state_d = RD_WAIT;
            cnt_d   = CNT_W'(MEM_RD_LAT);
          end else begin
            state_d = RESP;
          end
        end
      end
      RD_WAIT: begin
        if (!psel) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_d == '0) begin
            cap     = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      region_q    <= ERR;
      idx_q       <= '0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_wdata_q <= '0;
      mem_wr_q    <= 1'b0;
      rw_wr_stb_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= REG_RST;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rw_wr_stb_q <= '0;
      mem_wr_q    <= 1'b0;
      if (setup_idle) begin
        region_q <= dec_region;
        idx_q    <= dec_idx;
        write_q  <= pwrite;
      end
      if (acc_idle) err_q <= err_d;
      if (cap) rdata_q <= mem_rdata;
      if (rw_commit) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (idx_q == IDX_W'(i)) begin
            rw_wr_stb_q[i] <= 1'b1;
            for (int b = 0; b < STRB_W; b++)
              if (strb_eff[b]) regs_q[i][b*8 +: 8] <= pwdata[b*8 +: 8];
          end
        end
      end
      if (mem_commit) begin
        mem_wr_q    <= 1'b1;
        mem_wdata_q <= pwdata;
      end
    end
  end

  // Response mux; RO words are taken live in the response cycle.
  always_comb begin
    prdata = '0;
    if (!rst && state_q == RESP && !write_q && !err_q) begin
      case (region_q)
        RW:  for (int i = 0; i < NUM_REGS; i++)
               if (idx_q == IDX_W'(i)) prdata = regs_q[i];
        RO:  for (int i = 0; i < NUM_REGS; i++)
               if (idx_q == IDX_W'(i)) prdata = ro_d[i*DATA_W +: DATA_W];
        MEM: prdata = rdata_q;
        default: prdata = '0;
      endcase
    end
  end

  assign pready    = !rst && state_q == RESP;
  assign pslverr   = pready && err_q;
  assign rw_q      = regs_q;
  assign rw_wr_stb = rw_wr_stb_q;
  assign mem_addr  = idx_q[MEM_AW-1:0];
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
